// File: rtl/magia_launch_pkg.sv
// Shared types and defaults for the MAGIA tile launch sequencer.
package magia_launch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENABLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE,
        ST_TOUT
    } launch_state_e;

    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_SLEEP_FILTER  = 4;

    typedef logic [31:0] hartid_t;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/magia_launch_ptr.sv
// Launch pointer helper: lowest set mask bit, and the next set bit above
// the current pointer together with a flag when no such bit exists.
module magia_launch_ptr #(
    parameter int unsigned N_TILES = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [N_TILES-1:0] mask,
    input  logic [PTR_W-1:0]   cur_idx,
    output logic [PTR_W-1:0]   first_idx,
    output logic [PTR_W-1:0]   next_idx,
    output logic               is_last
);

    // Scan from the top bit down so the lowest qualifying bit is written last.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        is_last   = 1'b1;
        for (int unsigned k = 0; k < N_TILES; k++) begin
            if (mask[N_TILES-1-k]) begin
                first_idx = PTR_W'(N_TILES - 1 - k);
                if (PTR_W'(N_TILES - 1 - k) > cur_idx) begin
                    next_idx = PTR_W'(N_TILES - 1 - k);
                    is_last  = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/magia_tile_launch_ctrl.sv
// Bring-up sequencer for N MAGIA tiles: enable, staggered fetch launch,
// sleep-based completion detection with timeout/abort, and wu_wfe forwarding.
module magia_tile_launch_ctrl
    import magia_launch_pkg::*;
#(
    parameter int unsigned N_TILES       = 4,
    parameter int unsigned HARTID_BASE   = 0,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SLEEP_FILTER  = DEF_SLEEP_FILTER,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [N_TILES-1:0]    tile_mask_i,
    input  logic [31:0]           boot_addr_i,
    input  logic [7:0]            stagger_i,
    input  logic [CNT_W-1:0]      timeout_i,
    input  logic [N_TILES-1:0]    core_sleep_i,
    input  logic [N_TILES-1:0]    wake_req_i,
    output logic [N_TILES-1:0]    tile_enable_o,
    output logic [N_TILES-1:0]    fetch_enable_o,
    output logic [N_TILES-1:0]    wu_wfe_o,
    output logic [31:0]           boot_addr_o,
    output logic [N_TILES*32-1:0] mhartid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      cycles_o
);

    localparam int unsigned PTR_W    = idx_width(N_TILES);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned FILT_W   = $clog2(SLEEP_FILTER + 1);

    launch_state_e        state_q, state_d;
    logic [N_TILES-1:0]   mask_q, mask_d;
    logic [31:0]          boot_q, boot_d;
    logic [7:0]           stagger_q, stagger_d;
    logic [N_TILES-1:0]   tile_en_q, tile_en_d;
    logic [N_TILES-1:0]   fetch_q, fetch_d;
    logic [N_TILES-1:0]   wu_wfe_q, wu_wfe_d;
    logic [N_TILES-1:0]   wake_q;
    logic [CNT_W-1:0]     cycles_q, cycles_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [7:0]           wait_q, wait_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [FILT_W-1:0]    filt_q, filt_d;
    logic                 relaunch_q, relaunch_d;

    logic [PTR_W-1:0]     first_ptr;
    logic [PTR_W-1:0]     next_ptr;
    logic                 ptr_last;
    logic [N_TILES-1:0]   wake_rise;
    logic                 all_asleep;
    logic [CNT_W-1:0]     cycles_inc;
    logic [N_TILES-1:0]   launch_mask;

    magia_launch_ptr #(
        .N_TILES (N_TILES),
        .PTR_W   (PTR_W)
    ) u_ptr (
        .mask      (mask_q),
        .cur_idx   (ptr_q),
        .first_idx (first_ptr),
        .next_idx  (next_ptr),
        .is_last   (ptr_last)
    );

    // Hart IDs are fixed straps derived from the tile index.
    for (genvar g = 0; g < N_TILES; g++) begin : g_hartid
        assign mhartid_o[g*32 +: 32] = hartid_t'(HARTID_BASE + g);
    end

    assign wake_rise  = wake_req_i & ~wake_q & fetch_q;
    assign all_asleep = ((core_sleep_i & mask_q) == mask_q);
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    // Next-state and datapath updates; abort overrides every state.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        boot_d      = boot_q;
        stagger_d   = stagger_q;
        tile_en_d   = tile_en_q;
        fetch_d     = fetch_q;
        wu_wfe_d    = wake_rise;
        cycles_d    = cycles_q;
        settle_d    = settle_q;
        wait_d      = wait_q;
        ptr_d       = ptr_q;
        filt_d      = filt_q;
        relaunch_d  = relaunch_q;
        launch_mask = relaunch_q ? mask_q : tile_mask_i;

        if (abort_i) begin
            state_d    = ST_IDLE;
            tile_en_d  = '0;
            fetch_d    = '0;
            wu_wfe_d   = '0;
            relaunch_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A relaunch armed from DONE/TOUT already holds its sampled values.
                    if (start_i || relaunch_q) begin
                        if (!relaunch_q) begin
                            mask_d    = tile_mask_i;
                            boot_d    = boot_addr_i;
                            stagger_d = stagger_i;
                            cycles_d  = '0;
                        end
                        relaunch_d = 1'b0;
                        if (launch_mask == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            tile_en_d = launch_mask;
                            settle_d  = '0;
                            state_d   = ST_ENABLE;
                        end
                    end
                end
                ST_ENABLE: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        ptr_d   = first_ptr;
                        wait_d  = '0;
                        state_d = ST_LAUNCH;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    if (wait_q > 8'd1) begin
                        wait_d = wait_q - 8'd1;
                    end else if (stagger_q == 8'd0) begin
                        fetch_d = fetch_q | mask_q;
                        filt_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        fetch_d[ptr_q] = 1'b1;
                        if (ptr_last) begin
                            filt_d  = '0;
                            state_d = ST_RUN;
                        end else begin
                            ptr_d  = next_ptr;
                            wait_d = stagger_q;
                        end
                    end
                end
                ST_RUN: begin
                    cycles_d = cycles_inc;
                    if (!all_asleep || (wake_rise != '0)) begin
                        filt_d = '0;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
                    if (all_asleep && (wake_rise == '0) &&
                        (filt_q == FILT_W'(SLEEP_FILTER - 1))) begin
                        state_d = ST_DONE;
                    end else if ((timeout_i != '0) && (cycles_inc >= timeout_i)) begin
                        state_d = ST_TOUT;
                    end
                end
                ST_DONE, ST_TOUT: begin
                    if (start_i) begin
                        mask_d     = tile_mask_i;
                        boot_d     = boot_addr_i;
                        stagger_d  = stagger_i;
                        cycles_d   = '0;
                        tile_en_d  = '0;
                        fetch_d    = '0;
                        wu_wfe_d   = '0;
                        relaunch_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            boot_q     <= '0;
            stagger_q  <= '0;
            tile_en_q  <= '0;
            fetch_q    <= '0;
            wu_wfe_q   <= '0;
            wake_q     <= '0;
            cycles_q   <= '0;
            settle_q   <= '0;
            wait_q     <= '0;
            ptr_q      <= '0;
            filt_q     <= '0;
            relaunch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            boot_q     <= boot_d;
            stagger_q  <= stagger_d;
            tile_en_q  <= tile_en_d;
            fetch_q    <= fetch_d;
            wu_wfe_q   <= wu_wfe_d;
            wake_q     <= wake_req_i;
            cycles_q   <= cycles_d;
            settle_q   <= settle_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            filt_q     <= filt_d;
            relaunch_q <= relaunch_d;
        end
    end

    assign tile_enable_o  = tile_en_q;
    assign fetch_enable_o = fetch_q;
    assign wu_wfe_o       = wu_wfe_q;
    assign boot_addr_o    = boot_q;
    assign cycles_o       = cycles_q;
    assign busy_o         = (state_q == ST_ENABLE) || (state_q == ST_LAUNCH) ||
                            (state_q == ST_RUN);
    assign done_o         = (state_q == ST_DONE);
    assign timeout_o      = (state_q == ST_TOUT);

endmodule

// File: tb/tb_magia_tile_launch_ctrl.sv
// Directed bench for magia_tile_launch_ctrl: launch-timing table plus
// hand-written completion, wake, timeout, abort, empty-mask and reset sequences.
module tb_magia_tile_launch_ctrl;

    localparam int NT = 4;
    localparam int NV = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [NT-1:0]   tile_mask = '0;
    logic [31:0]     boot_addr = '0;
    logic [7:0]      stagger = '0;
    logic [31:0]     timeout = '0;
    logic [NT-1:0]   core_sleep = '0;
    logic [NT-1:0]   wake_req = '0;
    logic [NT-1:0]   tile_enable;
    logic [NT-1:0]   fetch_enable;
    logic [NT-1:0]   wu_wfe;
    logic [31:0]     boot_addr_out;
    logic [NT*32-1:0] mhartid;
    logic            busy;
    logic            done;
    logic            tout;
    logic [31:0]     cycles;

    int n_cmp = 0;
    int n_err = 0;

    magia_tile_launch_ctrl #(
        .N_TILES       (NT),
        .HARTID_BASE   (16),
        .SETTLE_CYCLES (8),
        .SLEEP_FILTER  (4),
        .CNT_W         (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .tile_mask_i    (tile_mask),
        .boot_addr_i    (boot_addr),
        .stagger_i      (stagger),
        .timeout_i      (timeout),
        .core_sleep_i   (core_sleep),
        .wake_req_i     (wake_req),
        .tile_enable_o  (tile_enable),
        .fetch_enable_o (fetch_enable),
        .wu_wfe_o       (wu_wfe),
        .boot_addr_o    (boot_addr_out),
        .mhartid_o      (mhartid),
        .busy_o         (busy),
        .done_o         (done),
        .timeout_o      (tout),
        .cycles_o       (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NT-1:0] mask;
        logic [7:0]    stag;
        logic [31:0]   boot;
        int            r0;
        int            r1;
        int            r2;
        int            r3;
        int            run_t;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input logic [NT-1:0] m, input logic [7:0] s, input logic [31:0] b);
        tile_mask = m;
        stagger   = s;
        boot_addr = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int            rise [NT];
        int            run_seen;
        logic [NT-1:0] stray;
        int            exp_r [NT];

        vecs[0] = '{4'b1011, 8'd3, 32'h8000_0000, 9, 12, NV, 15, 16};
        vecs[1] = '{4'b0100, 8'd5, 32'h1C00_0080, NV, NV, 9, NV, 10};
        vecs[2] = '{4'b1111, 8'd0, 32'h0000_1000, 9, 9, 9, 9, 10};
        vecs[3] = '{4'b1010, 8'd1, 32'hDEAD_BEE0, NV, 9, NV, 10, 11};
        vecs[4] = '{4'b1001, 8'd2, 32'h0000_0004, 9, NV, NV, 11, 12};

        // Reset values
        ticks(3);
        check("rst_tile_en", tile_enable, 0);
        check("rst_fetch", fetch_enable, 0);
        check("rst_flags", {busy, done, tout}, 0);
        check("rst_cycles", cycles, 0);
        check("rst_boot", boot_addr_out, 0);
        check("rst_hartid", mhartid, {32'd19, 32'd18, 32'd17, 32'd16});
        rst_n = 1'b1;
        tick();

        // Launch timing table
        for (int v = 0; v < 5; v++) begin
            exp_r[0] = vecs[v].r0;
            exp_r[1] = vecs[v].r1;
            exp_r[2] = vecs[v].r2;
            exp_r[3] = vecs[v].r3;
            for (int i = 0; i < NT; i++) rise[i] = NV;
            run_seen = NV;
            stray = '0;
            launch(vecs[v].mask, vecs[v].stag, vecs[v].boot);
            check($sformatf("v%0d_tile_en", v), tile_enable, vecs[v].mask);
            check($sformatf("v%0d_boot", v), boot_addr_out, vecs[v].boot);
            for (int t = 1; t <= 20; t++) begin
                tick();
                stray |= (tile_enable | fetch_enable) & ~vecs[v].mask;
                for (int i = 0; i < NT; i++)
                    if (fetch_enable[i] && rise[i] == NV) rise[i] = t;
                if (cycles == 1 && run_seen == NV) run_seen = t;
            end
            for (int i = 0; i < NT; i++)
                check($sformatf("v%0d_rise%0d", v, i), rise[i], exp_r[i]);
            check($sformatf("v%0d_run", v), run_seen, vecs[v].run_t);
            check($sformatf("v%0d_stray", v), stray, 0);
            do_abort();
            check($sformatf("v%0d_abort_busy", v), busy, 0);
        end

        // Sequence A: launch, then all masked tiles sleep 20 cycles into RUN
        launch(4'b1011, 8'd3, 32'h8000_0000);
        ticks(15);
        check("A_fetch", fetch_enable, 4'b1011);
        ticks(20);
        check("A_cycles20", cycles, 20);
        core_sleep = 4'b1011;
        ticks(3);
        check("A_done_early", done, 0);
        tick();
        check("A_done", {done, busy}, 2'b10);
        check("A_cycles", cycles, 24);
        ticks(3);
        check("A_hold_cycles", cycles, 24);
        check("A_hold_en", {tile_enable, fetch_enable}, {4'b1011, 4'b1011});
        core_sleep = '0;

        // Sequence B: restart from DONE, then a wake pulse breaks the filter
        launch(4'b1111, 8'd1, 32'h0000_2000);
        check("B_gap", {tile_enable, fetch_enable, busy, done}, 0);
        check("B_cycles_clr", cycles, 0);
        tick();
        check("B_relaunch", {tile_enable, busy}, {4'b1111, 1'b1});
        check("B_boot", boot_addr_out, 32'h0000_2000);
        ticks(12);
        check("B_fetch", fetch_enable, 4'b1111);
        core_sleep = 4'b1111;
        ticks(3);
        wake_req = 4'b0010;
        tick();
        check("B_wfe_pulse", wu_wfe, 4'b0010);
        tick();
        check("B_wfe_once", wu_wfe, 0);
        ticks(2);
        check("B_done_wait", done, 0);
        tick();
        check("B_done", done, 1);
        check("B_cycles", cycles, 8);
        wake_req = '0;
        core_sleep = '0;

        // Sequence C: timeout with tile 0 never sleeping
        do_abort();
        check("C_abort_flags", {busy, done, tout}, 0);
        check("C_abort_cycles", cycles, 8);
        timeout = 50;
        core_sleep = 4'b1110;
        launch(4'b1111, 8'd0, 32'h0);
        check("C_cycles_clr", cycles, 0);
        ticks(9);
        check("C_fetch", fetch_enable, 4'b1111);
        ticks(49);
        check("C_no_tout", tout, 0);
        tick();
        check("C_tout", {tout, done, busy}, 3'b100);
        check("C_cycles", cycles, 50);
        check("C_hold_en", {tile_enable, fetch_enable}, 8'hFF);
        ticks(2);
        check("C_frozen", cycles, 50);
        core_sleep = '0;
        timeout = 0;

        // Sequence D: abort mid-launch, abort beating start, clean relaunch
        do_abort();
        launch(4'b1111, 8'd3, 32'h0);
        ticks(12);
        check("D_partial", fetch_enable, 4'b0011);
        do_abort();
        check("D_abort", {tile_enable, fetch_enable, busy}, 0);
        tile_mask = 4'b1111;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("D_abort_wins", {tile_enable, busy}, 0);
        tick();
        check("D_start_dropped", {tile_enable, busy}, 0);
        launch(4'b0110, 8'd2, 32'h0000_3000);
        check("D_relaunch", tile_enable, 4'b0110);
        ticks(9);
        check("D_first", fetch_enable, 4'b0010);
        ticks(2);
        check("D_second", fetch_enable, 4'b0110);

        // Sequence E: empty mask goes straight to DONE
        do_abort();
        launch(4'b0000, 8'd1, 32'h0);
        check("E_done", {done, busy, tile_enable}, {1'b1, 1'b0, 4'b0000});
        ticks(3);
        check("E_hold", {tile_enable, fetch_enable, done}, 9'h001);

        // Sequence F: asynchronous reset in the middle of RUN
        do_abort();
        launch(4'b1111, 8'd0, 32'h0000_4000);
        ticks(14);
        check("F_cycles", cycles, 5);
        wake_req = 4'b0001;
        tick();
        check("F_wfe", wu_wfe, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("F_rst_out", {tile_enable, fetch_enable, wu_wfe, busy, done, tout}, 0);
        check("F_rst_cnt", {cycles, boot_addr_out}, 0);
        check("F_rst_hartid", mhartid, {32'd19, 32'd18, 32'd17, 32'd16});
        wake_req = '0;
        tick();
        rst_n = 1'b1;
        ticks(2);
        check("F_after", {tile_enable, fetch_enable, busy, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/magia_tile_launch_ctrl.md
Name: magia_tile_launch_ctrl

Overview:
Synthesizable bring-up sequencer for N MAGIA tiles. It drives tile_enable, fetch_enable, boot address and hart IDs, and launches cores with a programmable stagger. It monitors core_sleep to detect end-of-computation, with timeout and abort. It also forwards single-cycle wu_wfe pulses, replacing the static strap values used for single-tile bring-up.

Parameters:
N_TILES, 4, number of tiles controlled (1..32)
HARTID_BASE, 0, mhartid of tile 0; tile i gets HARTID_BASE+i
SETTLE_CYCLES, 8, cycles between tile_enable and first fetch_enable (>=1)
SLEEP_FILTER, 4, consecutive all-asleep cycles required to declare done (>=1)
CNT_W, 32, width of cycle/timeout counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  launch request pulse, sampled in IDLE only
abort_i  in  1  abort; highest priority in every state
tile_mask_i  in  N_TILES  tiles to launch, sampled on start
boot_addr_i  in  32  boot address, sampled on start
stagger_i  in  8  cycles between consecutive fetch_enable assertions, sampled on start
timeout_i  in  CNT_W  RUN-phase cycle limit; 0 = no timeout
core_sleep_i  in  N_TILES  per-tile core_sleep_o
wake_req_i  in  N_TILES  per-tile wake request
tile_enable_o  out  N_TILES  per-tile tile_enable_i
fetch_enable_o  out  N_TILES  per-tile fetch_enable_i
wu_wfe_o  out  N_TILES  per-tile wu_wfe_i pulse
boot_addr_o  out  32  latched boot address, common to all tiles
mhartid_o  out  N_TILES*32  packed hart IDs, constant
busy_o  out  1  high in ENABLE, LAUNCH, RUN
done_o  out  1  high in DONE
timeout_o  out  1  high in TOUT
cycles_o  out  CNT_W  RUN-phase cycle count, held after completion

Behaviour:
- Reset: all outputs 0 except mhartid_o (constant); state IDLE; latched mask/addr/stagger cleared.
- States: IDLE, ENABLE, LAUNCH, RUN, DONE, TOUT.
- IDLE: on start_i, latch mask/boot_addr/stagger and clear cycles_o.
  - If the mask is zero, go directly to DONE.
  - Otherwise, next cycle tile_enable_o = mask and go to ENABLE.
- ENABLE: count SETTLE_CYCLES, then go to LAUNCH with the launch pointer at the lowest set mask bit.
- LAUNCH: set fetch_enable_o[ptr]; the bit stays set until exit to IDLE.
  - Then wait stagger cycles before the next set mask bit.
  - stagger=0 means all remaining masked tiles are asserted in the same cycle.
  - Go to RUN in the cycle after the highest masked tile is asserted.
  - Unmasked tiles never receive tile_enable or fetch_enable.
- RUN: cycles_o increments each cycle, saturating at all-ones.
  - A filter counter increments while (core_sleep_i & mask) == mask and resets to 0 on any masked awake tile.
  - Filter reaching SLEEP_FILTER moves to DONE.
  - If timeout_i != 0 and cycles_o reaches timeout_i, move to TOUT.
  - If done and timeout trigger in the same cycle, done wins.
- core_sleep_i is ignored outside RUN. A tile sleeping during LAUNCH does not count toward done.
- wu_wfe_o[i] is a 1-cycle pulse on the rising edge of wake_req_i[i], and only if fetch_enable_o[i] is set.
  - Held requests do not retrigger.
  - A pulse during RUN resets the filter counter.
- DONE/TOUT: outputs hold (enables stay set, cycles_o frozen).
  - start_i returns to IDLE, deasserting all enables for one cycle, then relaunches.
  - A new start_i issued in DONE/TOUT is consumed by the return to IDLE. The relaunch uses values sampled on that cycle.
- abort_i: from any state, next cycle is IDLE with all enables cleared, wu_wfe cleared and flags cleared.
  - cycles_o is held.
  - abort_i and start_i in the same cycle: abort wins.
- Counter widths: the stagger counter is 8 bits and the settle counter is $clog2(SETTLE_CYCLES+1).
- Reset asserted mid-operation: asynchronous return to reset values, no pending pulses retained.

Decomposition:
- Shared package magia_launch_pkg holds:
  - launch_state_e (the six states);
  - default constants for SETTLE_CYCLES and SLEEP_FILTER;
  - hartid_t = logic[31:0].
- Sub-module magia_launch_ptr: next-set-bit finder over the mask above the current pointer (combinational priority encoder plus a "last" flag). Used by LAUNCH.
- Wake edge detect and counters stay inline.

Test Plan:
1. mask=4'b1011, stagger=3, SETTLE=8, timeout=0 -> tile_enable=1011 one cycle after start. fetch_enable bits 0,1,3 rise at cycles 9, 12, 15 after tile_enable. Bit 2 never asserts.
2. All masked tiles assert sleep 20 cycles into RUN and hold -> done_o rises after SLEEP_FILTER=4 cycles; cycles_o = 24.
3. Sleep broken at filter count 3 by wake_req_i[1] -> wu_wfe_o[1] pulses 1 cycle, filter restarts, done_o is delayed by 4 cycles from the next all-asleep cycle.
4. timeout=50, tile 0 never sleeps -> timeout_o at RUN cycle 50, done_o stays 0, enables held.
5. abort_i during LAUNCH after 2 of 4 tiles -> next cycle all enables 0 and busy_o 0; a following start relaunches cleanly.
6. mask=0 on start -> DONE next cycle, no enables ever asserted. Also check async reset mid-RUN clears all outputs immediately.
